// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared constants and helpers for the 45-bit four-segment SIMD
//             ALU output stage (segments 17/10/8/10 bits).
//             - USE_SIMD mode encodings
//             - segment boundary LSB positions
//             - AUTORESET_PATDET encodings
//             - per-mode carry-keep masks and a lookup helper
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam int C_P_WIDTH     = 45;
    localparam int C_CARRY_WIDTH = 8;

    // USE_SIMD encodings
    typedef enum logic [1:0] {
        MODE_27X18   = 2'b00,
        MODE_SUM_9X9 = 2'b01,
        MODE_SUM_4X4 = 2'b10,
        MODE_ILLEGAL = 2'b11
    } simd_mode_e;

    // LSB position of each ALU segment, segment 0 first
    localparam int C_SEG_LSB [4] = '{0, 17, 27, 35};

    // AUTORESET_PATDET encodings
    localparam logic [1:0] C_AR_OFF   = 2'b00;
    localparam logic [1:0] C_AR_MATCH = 2'b01;
    localparam logic [1:0] C_AR_LOSS  = 2'b10;

    // Carry pairs that leave a SIMD lane in each mode; all others are
    // internal to a wider lane and must not reach CARRYOUT.
    localparam logic [7:0] C_KEEP_27X18   = 8'hC0;
    localparam logic [7:0] C_KEEP_SUM_9X9 = 8'hCC;
    localparam logic [7:0] C_KEEP_SUM_4X4 = 8'hFF;

    function automatic logic [7:0] carry_keep(input simd_mode_e mode);
        case (mode)
            MODE_27X18:   return C_KEEP_27X18;
            MODE_SUM_9X9: return C_KEEP_SUM_9X9;
            MODE_SUM_4X4: return C_KEEP_SUM_4X4;
            default:      return 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_p_register_patdet_pattern_compare.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_compare
//  Purpose  : Combinational masked equality of a value against a pattern and
//             against the pattern's complement. MASK bit = 1 is don't-care.
//  Ports    : i_value   - value under test
//             i_pattern - compare pattern
//             i_mask    - don't-care mask
//             o_detect  - (value & ~mask) == (pattern & ~mask)
//             o_bdetect - (value & ~mask) == (~pattern & ~mask)
//  Revision : 1.0  initial release
// ============================================================================
module pattern_compare #(
    parameter int WIDTH = 45
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [WIDTH-1:0] i_pattern,
    input  logic [WIDTH-1:0] i_mask,
    output logic             o_detect,
    output logic             o_bdetect
);

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_bdiff;

    assign w_diff    = (i_value ^  i_pattern) & ~i_mask;
    assign w_bdiff   = (i_value ^ ~i_pattern) & ~i_mask;
    assign o_detect  = (w_diff  == '0);
    assign o_bdetect = (w_bdiff == '0);

endmodule
`default_nettype wire

// File: rtl/alu_p_register_patdet.sv
`default_nettype none
// ============================================================================
//  Module   : alu_p_register_patdet
//  Purpose  : P-register output stage behind the 45-bit SIMD ALU. Registers
//             the ALU sum and mode-masked carries, detects masked patterns,
//             flags overflow/underflow and optionally auto-resets P.
//  Ports    : clk                  - clock
//             reset                - synchronous active-high reset
//             CEP                  - clock enable for P, CARRYOUT and flags
//             USE_SIMD[1:0]        - 00 27x18, 01 sum_9x9, 10 sum_4x4, 11 illegal
//             S[44:0]              - ALU sum
//             result_SIMD_carry_in - raw carry pairs, segment k at [2k+1:2k]
//             PATTERN[44:0]        - compare pattern
//             MASK[44:0]           - compare mask, 1 = don't-care
//             P[44:0]              - result
//             CARRYOUT[7:0]        - mode-masked carries
//             PATTERNDETECT        - P matches PATTERN under MASK
//             PATTERNBDETECT       - P matches ~PATTERN under MASK
//             OVERFLOW/UNDERFLOW   - match lost after PD / PBD
//  Revision : 1.0  initial release
// ============================================================================
module alu_p_register_patdet
    import alu_pkg::*;
#(
    parameter int          PREG             = 1,
    parameter logic [1:0]  AUTORESET_PATDET = 2'b00,
    parameter logic [44:0] PATTERN_INIT     = 45'd0,
    parameter logic [44:0] MASK_INIT        = 45'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CEP,
    input  logic [1:0]  USE_SIMD,
    input  logic [44:0] S,
    input  logic [7:0]  result_SIMD_carry_in,
    input  logic [44:0] PATTERN,
    input  logic [44:0] MASK,
    output logic [44:0] P,
    output logic [7:0]  CARRYOUT,
    output logic        PATTERNDETECT,
    output logic        PATTERNBDETECT,
    output logic        OVERFLOW,
    output logic        UNDERFLOW
);

    logic [44:0] r_p;
    logic [7:0]  r_carry;
    logic        r_pd;
    logic        r_pbd;
    logic        r_pd_past;
    logic        r_pbd_past;

    logic [44:0] w_pattern;
    logic [44:0] w_mask;
    logic        w_illegal;
    logic        w_ar_match;
    logic        w_ar_loss;
    logic        w_autoreset;
    logic [7:0]  w_carry_masked;
    logic [44:0] w_p_next;
    logic [7:0]  w_carry_next;
    logic        w_pd_next;
    logic        w_pbd_next;

    // While reset is held the compare falls back to the init values so the
    // combinational bypass path never sees an undefined pattern.
    assign w_pattern = reset ? PATTERN_INIT : PATTERN;
    assign w_mask    = reset ? MASK_INIT    : MASK;

    assign w_illegal      = (simd_mode_e'(USE_SIMD) == MODE_ILLEGAL);
    assign w_carry_masked = result_SIMD_carry_in & carry_keep(simd_mode_e'(USE_SIMD));

    // Auto-reset only exists when there is a P register to clear.
    assign w_ar_match  = (AUTORESET_PATDET == C_AR_MATCH) && r_pd;
    assign w_ar_loss   = (AUTORESET_PATDET == C_AR_LOSS) && r_pd_past && !r_pd;
    assign w_autoreset = (PREG != 0) && CEP && (w_ar_match || w_ar_loss);

    always_comb begin
        w_p_next     = S;
        w_carry_next = w_carry_masked;
        if (w_autoreset) begin
            w_p_next = '0;
            if (w_ar_match) begin
                w_carry_next = '0;
            end
        end else if (w_illegal) begin
            w_p_next = r_p;
        end
    end

    pattern_compare #(
        .WIDTH (C_P_WIDTH)
    ) u_pattern_compare (
        .i_value   (w_p_next),
        .i_pattern (w_pattern),
        .i_mask    (w_mask),
        .o_detect  (w_pd_next),
        .o_bdetect (w_pbd_next)
    );

    // Past-state captures the detect values visible before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p        <= '0;
            r_carry    <= '0;
            r_pd       <= 1'b0;
            r_pbd      <= 1'b0;
            r_pd_past  <= 1'b0;
            r_pbd_past <= 1'b0;
        end else if (CEP) begin
            r_p        <= w_p_next;
            r_carry    <= w_carry_next;
            r_pd       <= w_pd_next;
            r_pbd      <= w_pbd_next;
            r_pd_past  <= PATTERNDETECT;
            r_pbd_past <= PATTERNBDETECT;
        end
    end

    generate
        if (PREG != 0) begin : g_preg
            assign P              = r_p;
            assign CARRYOUT       = r_carry;
            assign PATTERNDETECT  = r_pd;
            assign PATTERNBDETECT = r_pbd;
        end else begin : g_bypass
            assign P              = w_p_next;
            assign CARRYOUT       = w_carry_next;
            assign PATTERNDETECT  = w_pd_next;
            assign PATTERNBDETECT = w_pbd_next;
        end
    endgenerate

    assign OVERFLOW  = r_pd_past  & ~PATTERNDETECT & ~PATTERNBDETECT;
    assign UNDERFLOW = r_pbd_past & ~PATTERNDETECT & ~PATTERNBDETECT;

endmodule
`default_nettype wire

// File: doc/alu_p_register_patdet.md
Name: alu_p_register_patdet

Overview:
Output stage directly downstream of the 45-bit four-segment SIMD ALU (segments 17/10/8/10 bits, modes 27x18, sum_9x9, sum_4x4).
- Registers the ALU sum S and the 8-bit SIMD carry-out vector into P/CARRYOUT.
- Performs masked pattern detection and overflow/underflow flagging.
- Optionally auto-resets P, as the DSP48-style accumulator P register does.
- P is fed back to the ALU Z-mux for accumulation.

Parameters:
- PREG, 1, 1 = P/flags registered (1-cycle latency); 0 = combinational bypass (flags still valid same cycle; OVERFLOW/UNDERFLOW still use the registered past-state).
- AUTORESET_PATDET, 2'b00, 00 = off; 01 = reset P on match; 10 = reset P on loss of match after a match.
- PATTERN_INIT, 45'd0, default pattern used at reset.
- MASK_INIT, 45'h1FFF_FFFF_FFFF >> ... = 45'd0, default mask (0 = bit compared).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- CEP  in  1  clock enable for P, CARRYOUT and flags
- USE_SIMD  in  2  00 = 27x18, 01 = sum_9x9, 10 = sum_4x4, 11 = illegal
- S  in  45  ALU sum
- result_SIMD_carry_in  in  8  raw per-segment carry pairs from the ALU (2 bits per segment, segment k at [2k+1:2k])
- PATTERN  in  45  compare pattern
- MASK  in  45  compare mask; 1 = don't-care bit
- P  out  45  registered result
- CARRYOUT  out  8  mode-masked carries
- PATTERNDETECT  out  1  (P & ~MASK) == (PATTERN & ~MASK)
- PATTERNBDETECT  out  1  (P & ~MASK) == (~PATTERN & ~MASK)
- OVERFLOW  out  1  see Behaviour
- UNDERFLOW  out  1  see Behaviour

Behaviour:
- Reset (reset=1 at posedge, overrides CEP): P=0, CARRYOUT=0, PATTERNDETECT=0, PATTERNBDETECT=0, OVERFLOW=0, UNDERFLOW=0, internal pd_past=0, pbd_past=0.
- PREG=1: at posedge with CEP=1, P<=S_eff, CARRYOUT<=carry_masked; flags are computed from the next-P value and registered in the same edge. Latency S->P = 1 cycle. CEP=0 holds all outputs and past-state.
- Carry masking by mode. Only segment-boundary carries that leave a SIMD lane survive; others are forced 0:
  - 27x18: keep [7:6], zero [5:0].
  - sum_9x9: keep [3:2] and [7:6], zero [1:0] and [5:4].
  - sum_4x4: keep all 8.
  - 11: CARRYOUT<=8'h00 and P<=P (hold).
- Pattern compare is full 45-bit width in every mode.
- Auto-reset computes S_eff with priority reset > autoreset > load:
  - mode 01: if PATTERNDETECT (current registered) = 1 and CEP=1, next P=0 and CARRYOUT=0, regardless of S.
  - mode 10: if pd_past=1 and PATTERNDETECT=0 and CEP=1, next P=0.
- Past-state: on each CEP edge, pd_past<=PATTERNDETECT and pbd_past<=PATTERNBDETECT (pre-update values).
- Flags:
  - OVERFLOW = pd_past & ~PATTERNDETECT & ~PATTERNBDETECT.
  - UNDERFLOW = pbd_past & ~PATTERNDETECT & ~PATTERNBDETECT.
  - Both are combinational from registered state. They are mutually exclusive only if PATTERN ≠ ~PATTERN under the mask; if MASK is all ones, both detects are 1 and both flags are 0.
- PREG=0: P=S_eff combinationally; auto-reset is ignored (no state to reset). Past registers still update on CEP.
- Reset asserted mid-accumulation discards the in-flight S; the first CEP edge after reset deassertion loads S.

Decomposition:
- Shared package alu_pkg holds:
  - USE_SIMD mode constants MODE_27X18/MODE_SUM_9X9/MODE_SUM_4X4.
  - Segment boundary constants SEG_LSB = {0,17,27,35}.
  - AUTORESET encodings.
  - Carry-keep masks per mode: 8'hC0, 8'hCC, 8'hFF.
- One sub-module, pattern_compare: a combinational masked equality producing detect/bdetect for a given value. It is instanced once on next-P (registered path) and reused for PREG=0.

Test Plan:
- Reset: reset=1 with S=45'h1_2345_6789, CEP=1 -> P=0, CARRYOUT=0, all flags 0 next cycle.
- Load/hold: USE_SIMD=00, S=45'h0ABC, carry=8'hFF, CEP=1 -> P=45'h0ABC and CARRYOUT=8'hC0 after 1 cycle. Then CEP=0 with S=0 -> P stays 45'h0ABC.
- Mode masking: carry=8'hFF; USE_SIMD=01 -> CARRYOUT=8'hCC; USE_SIMD=10 -> 8'hFF; USE_SIMD=11 -> CARRYOUT=8'h00 and P held.
- Overflow: PATTERN=0, MASK=45'h0_0000_FFFF (upper 29 bits compared). Load S=45'h00FF (PD=1), then S=45'h1_0000 -> PATTERNDETECT=0, PATTERNBDETECT=0, OVERFLOW=1 for that cycle.
- Underflow: same MASK. Load S=45'h1FFF_FFFF_0000 (PBD=1), then S=45'h0_0001_0000 -> UNDERFLOW=1, OVERFLOW=0.
- Autoreset: AUTORESET_PATDET=01, PATTERN=45'd5, MASK=0. Load S=5 (PD=1), then S=9 -> P=0 rather than 9. With 10: load 5, then 9 -> P=9; next edge S=7 -> P=0.
